// File: rtl/k423_if_fetch_buf.sv
// k423 instruction-fetch front end.
// Issues sequential fetches with a bounded number in flight, tags each
// in-order response with the PC that requested it, queues the results in a
// small instruction buffer and streams them to ID. A branch flush redirects
// the PC, empties the buffer and marks every in-flight response as stale.
module k423_if_fetch_buf #(
  parameter int                ADDR_W    = 32,
  parameter int                INST_W    = 32,
  parameter int                OSTD_N    = 2,
  parameter int                BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RST_PC    = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pcu_stall_i,
  input  logic              pcu_flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              if_mem_req_vld_o,
  output logic              if_mem_req_wen_o,
  output logic [ADDR_W-1:0] if_mem_req_addr_o,
  output logic [INST_W-1:0] if_mem_req_wdata_o,
  input  logic              if_mem_req_rdy_i,
  input  logic              if_mem_rsp_vld_i,
  input  logic [INST_W-1:0] if_mem_rsp_rdata_i,
  output logic              if_stage_vld_o,
  input  logic              id_stage_rdy_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o
);

  localparam int CNT_W     = $clog2(OSTD_N) + 1;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int TAG_AW    = (OSTD_N > 1) ? $clog2(OSTD_N) : 1;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0]    pc;
  logic [CNT_W-1:0]     ostd_cnt;
  logic [CNT_W-1:0]     drop_cnt;
  logic [BUF_CNT_W-1:0] buf_cnt;

  logic [TAG_AW-1:0]    tag_wr_ptr;
  logic [TAG_AW-1:0]    tag_rd_ptr;
  logic [ADDR_W-1:0]    tag_mem [OSTD_N];

  logic [BUF_AW-1:0]    buf_head;
  logic [BUF_AW-1:0]    buf_tail;
  logic [ADDR_W-1:0]    buf_pc   [BUF_DEPTH];
  logic [INST_W-1:0]    buf_inst [BUF_DEPTH];

  logic credit;
  logic drop_room;
  logic req_vld;
  logic req_fire;
  logic rsp_fire;
  logic rsp_keep;
  logic out_vld;
  logic out_pop;

  // Pointer advance that also works for depths of one.
  function automatic logic [TAG_AW-1:0] tag_next(input logic [TAG_AW-1:0] p);
    return (int'(p) == OSTD_N - 1) ? '0 : p + TAG_AW'(1);
  endfunction

  function automatic logic [BUF_AW-1:0] buf_next(input logic [BUF_AW-1:0] p);
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + BUF_AW'(1);
  endfunction

  // Issue/handshake decode; every accepted request already owns a buffer slot.
  always_comb begin
    credit    = ((int'(ostd_cnt) + int'(buf_cnt)) < BUF_DEPTH) && (int'(ostd_cnt) < OSTD_N);
    drop_room = (int'(drop_cnt) + int'(ostd_cnt)) < OSTD_N;
    req_vld   = ~pcu_stall_i & ~pcu_flush_i & credit & drop_room;
    req_fire  = req_vld & if_mem_req_rdy_i;
    rsp_fire  = if_mem_rsp_vld_i & (ostd_cnt != '0);
    rsp_keep  = rsp_fire & (drop_cnt == '0) & ~pcu_flush_i;
    out_vld   = (buf_cnt != '0);
    out_pop   = out_vld & id_stage_rdy_i & ~pcu_flush_i;
  end

  assign if_mem_req_vld_o   = req_vld;
  assign if_mem_req_wen_o   = 1'b0;
  assign if_mem_req_addr_o  = pc;
  assign if_mem_req_wdata_o = '0;

  assign if_stage_vld_o = out_vld;
  assign if_pc_o        = out_vld ? buf_pc[buf_head]   : '0;
  assign if_inst_o      = out_vld ? buf_inst[buf_head] : '0;

  // PC: redirect on flush, otherwise step past each accepted request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc <= RST_PC;
    end else if (pcu_flush_i) begin
      pc <= flush_pc_i;
    end else if (req_fire) begin
      pc <= pc + PC_INC;
    end
  end

  // In-flight count and tag FIFO pointers; the FIFO keeps draining across flushes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ostd_cnt   <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   ostd_cnt <= ostd_cnt + CNT_W'(1);
        2'b01:   ostd_cnt <= ostd_cnt - CNT_W'(1);
        default: ostd_cnt <= ostd_cnt;
      endcase
      if (req_fire) tag_wr_ptr <= tag_next(tag_wr_ptr);
      if (rsp_fire) tag_rd_ptr <= tag_next(tag_rd_ptr);
    end
  end

  // Stale-response count. Responses already marked stale are a subset of
  // ostd_cnt, so after a flush everything still in flight is stale; this keeps
  // back-to-back flushes from counting the same response twice.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt <= '0;
    end else if (pcu_flush_i) begin
      drop_cnt <= drop_cnt + (ostd_cnt - drop_cnt) - (rsp_fire ? CNT_W'(1) : CNT_W'(0));
    end else if (rsp_fire && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // Instruction buffer control: flush empties it, otherwise push/pop together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= '0;
    end else if (pcu_flush_i) begin
      buf_head <= '0;
      buf_tail <= '0;
      buf_cnt  <= '0;
    end else begin
      if (rsp_keep) buf_tail <= buf_next(buf_tail);
      if (out_pop)  buf_head <= buf_next(buf_head);
      case ({rsp_keep, out_pop})
        2'b10:   buf_cnt <= buf_cnt + BUF_CNT_W'(1);
        2'b01:   buf_cnt <= buf_cnt - BUF_CNT_W'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Storage arrays; contents are only observed through valid pointers.
  always_ff @(posedge clk_i) begin
    if (req_fire) tag_mem[tag_wr_ptr] <= pc;
    if (rsp_keep) begin
      buf_pc[buf_tail]   <= tag_mem[tag_rd_ptr];
      buf_inst[buf_tail] <= if_mem_rsp_rdata_i;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(if_mem_rsp_vld_i && (ostd_cnt == '0)))
    else $error("k423_if_fetch_buf: response with no request outstanding");

endmodule

// File: tb/tb_k423_if_fetch_buf.sv
// Directed bench for k423_if_fetch_buf with an in-order memory model and an
// output scoreboard of expected {pc, inst} pairs.
module tb_k423_if_fetch_buf;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int OSTD_N    = 2;
  localparam int BUF_DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              pcu_stall_i;
  logic              pcu_flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic              if_mem_req_vld_o;
  logic              if_mem_req_wen_o;
  logic [ADDR_W-1:0] if_mem_req_addr_o;
  logic [INST_W-1:0] if_mem_req_wdata_o;
  logic              if_mem_req_rdy_i;
  logic              if_mem_rsp_vld_i;
  logic [INST_W-1:0] if_mem_rsp_rdata_i;
  logic              if_stage_vld_o;
  logic              id_stage_rdy_i;
  logic [ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0] if_inst_o;

  k423_if_fetch_buf #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .OSTD_N(OSTD_N),
    .BUF_DEPTH(BUF_DEPTH), .RST_PC(RST_PC)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .pcu_stall_i(pcu_stall_i), .pcu_flush_i(pcu_flush_i), .flush_pc_i(flush_pc_i),
    .if_mem_req_vld_o(if_mem_req_vld_o), .if_mem_req_wen_o(if_mem_req_wen_o),
    .if_mem_req_addr_o(if_mem_req_addr_o), .if_mem_req_wdata_o(if_mem_req_wdata_o),
    .if_mem_req_rdy_i(if_mem_req_rdy_i), .if_mem_rsp_vld_i(if_mem_rsp_vld_i),
    .if_mem_rsp_rdata_i(if_mem_rsp_rdata_i), .if_stage_vld_o(if_stage_vld_o),
    .id_stage_rdy_i(id_stage_rdy_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; bit stale; } mem_ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } out_ent_t;

  mem_ent_t    memq[$];
  out_ent_t    expq[$];
  logic [31:0] model_pc;
  int          total = 0;
  int          bad = 0;
  int          accepts = 0;
  int          pops = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, let memory answer the
  // oldest request, then check and update the model before the rising edge.
  task automatic apply_stimulus(input bit stall, input bit flush, input logic [31:0] fpc,
                                input bit mrdy, input bit rsp_en, input bit idrdy);
    mem_ent_t r;
    out_ent_t e;
    @(negedge clk_i);
    pcu_stall_i      = stall;
    pcu_flush_i      = flush;
    flush_pc_i       = fpc;
    if_mem_req_rdy_i = mrdy;
    id_stage_rdy_i   = idrdy;
    if (rsp_en && memq.size() != 0) begin
      if_mem_rsp_vld_i   = 1'b1;
      if_mem_rsp_rdata_i = inst_of(memq[0].addr);
    end else begin
      if_mem_rsp_vld_i   = 1'b0;
      if_mem_rsp_rdata_i = '0;
    end
    #1;
    check_output("stage_vld", 64'(if_stage_vld_o), 64'(expq.size() != 0));
    if (expq.size() != 0 && if_stage_vld_o) begin
      check_output("head_pc", 64'(if_pc_o), 64'(expq[0].pc));
      check_output("head_inst", 64'(if_inst_o), 64'(expq[0].inst));
      if (idrdy && !flush) begin
        void'(expq.pop_front());
        pops++;
      end
    end
    if (flush || stall) check_output("no_issue", 64'(if_mem_req_vld_o), 64'(0));
    if (if_mem_rsp_vld_i) begin
      r = memq.pop_front();
      if (!r.stale && !flush) begin
        e.pc   = r.addr;
        e.inst = inst_of(r.addr);
        expq.push_back(e);
      end
    end
    if (flush) begin
      expq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      model_pc = fpc;
    end else if (if_mem_req_vld_o && mrdy && !stall) begin
      check_output("req_addr", 64'(if_mem_req_addr_o), 64'(model_pc));
      r.addr  = model_pc;
      r.stale = 1'b0;
      memq.push_back(r);
      model_pc = model_pc + 32'd4;
      accepts++;
    end
  endtask

  // Let memory and ID empty everything out, with a cycle budget.
  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      if (memq.size() == 0 && expq.size() == 0) begin
        done = 1;
        break;
      end
      apply_stimulus(0, 0, '0, 0, 1, 1);
    end
    if (memq.size() == 0 && expq.size() == 0) done = 1;
    check_output("drain_done", 64'(done), 64'(1));
  endtask

  // Run normal traffic until the first output appears and check its PC.
  task automatic run_until_vld(input int budget, input logic [31:0] exp_pc, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      apply_stimulus(0, 0, '0, 1, 1, 1);
      if (if_stage_vld_o) begin
        seen = 1;
        break;
      end
    end
    check_output({tag, "_seen"}, 64'(seen), 64'(1));
    if (seen) check_output(tag, 64'(if_pc_o), 64'(exp_pc));
  endtask

  initial begin
    int          base;
    logic [31:0] saved_pc;

    rst_n_i            = 1'b0;
    pcu_stall_i        = 1'b0;
    pcu_flush_i        = 1'b0;
    flush_pc_i         = '0;
    if_mem_req_rdy_i   = 1'b0;
    if_mem_rsp_vld_i   = 1'b0;
    if_mem_rsp_rdata_i = '0;
    id_stage_rdy_i     = 1'b0;
    model_pc           = RST_PC;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check_output("rst_stage_vld", 64'(if_stage_vld_o), 64'(0));
    check_output("rst_pc_o", 64'(if_pc_o), 64'(0));
    check_output("rst_inst_o", 64'(if_inst_o), 64'(0));
    check_output("rst_req_addr", 64'(if_mem_req_addr_o), 64'(RST_PC));
    check_output("rst_wen", 64'(if_mem_req_wen_o), 64'(0));
    check_output("rst_wdata", 64'(if_mem_req_wdata_o), 64'(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Streaming: one request per cycle, outputs follow two cycles later
    $display("[TB] streaming");
    base = accepts;
    for (int i = 0; i < 12; i++) apply_stimulus(0, 0, '0, 1, 1, 1);
    check_output("stream_accepts", 64'(accepts - base), 64'(12));
    drain(20);

    // ID back-pressure fills the buffer, then drains and resumes
    $display("[TB] backpressure");
    base     = accepts;
    saved_pc = model_pc;
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, '0, 1, 1, 0);
    check_output("full_accepts", 64'(accepts - base), 64'(4));
    check_output("full_no_issue", 64'(if_mem_req_vld_o), 64'(0));
    check_output("full_head_pc", 64'(if_pc_o), 64'(saved_pc));
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, '0, 1, 1, 1);
    check_output("resume_issue", 64'((accepts - base) > 4), 64'(1));
    drain(20);

    // Flush with two requests in flight
    $display("[TB] flush");
    apply_stimulus(0, 0, '0, 1, 0, 1);
    apply_stimulus(0, 0, '0, 1, 0, 1);
    apply_stimulus(0, 0, '0, 1, 0, 1);
    check_output("ostd_limit", 64'(if_mem_req_vld_o), 64'(0));
    check_output("ostd_count", 64'(memq.size()), 64'(2));
    apply_stimulus(0, 1, 32'h0000_1000, 1, 0, 1);
    run_until_vld(12, 32'h0000_1000, "flush_first_pc");
    drain(20);

    // Flush together with a response and an ID pop, then a second flush
    $display("[TB] double flush");
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, '0, 1, 1, 1);
    apply_stimulus(0, 0, '0, 1, 0, 0);
    apply_stimulus(0, 1, 32'h1111_0000, 0, 1, 1);
    apply_stimulus(0, 1, 32'h0000_2000, 0, 1, 1);
    run_until_vld(12, 32'h0000_2000, "reflush_first_pc");
    drain(20);

    // Stall with one request outstanding
    $display("[TB] stall");
    apply_stimulus(0, 0, '0, 1, 0, 1);
    base     = pops;
    saved_pc = model_pc;
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, '0, 1, 1, 1);
    check_output("stall_delivered", 64'(pops - base), 64'(1));
    check_output("stall_pc_hold", 64'(if_mem_req_addr_o), 64'(saved_pc));
    base = accepts;
    apply_stimulus(0, 0, '0, 1, 1, 1);
    check_output("stall_resume", 64'(accepts - base), 64'(1));
    drain(20);

    // PC wrap at the top of the address space
    $display("[TB] wrap");
    apply_stimulus(0, 1, 32'hFFFF_FFFC, 0, 1, 1);
    apply_stimulus(0, 0, '0, 1, 1, 1);
    apply_stimulus(0, 0, '0, 1, 1, 1);
    check_output("wrap_addr", 64'(if_mem_req_addr_o), 64'(0));
    drain(20);

    // Asynchronous reset in the middle of traffic
    $display("[TB] mid reset");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, '0, 1, 1, 0);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_output("areset_stage_vld", 64'(if_stage_vld_o), 64'(0));
    check_output("areset_pc_o", 64'(if_pc_o), 64'(0));
    check_output("areset_req_addr", 64'(if_mem_req_addr_o), 64'(RST_PC));
    memq.delete();
    expq.delete();
    model_pc = RST_PC;
    apply_stimulus(0, 0, '0, 0, 0, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_until_vld(12, RST_PC, "post_reset_first_pc");
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
